// File: rtl/axi4_mem_slave_if.sv
// AXI4 bus between the NPC CPU master port and the memory slave model,
// bundled with the console byte sink.
interface axi4_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  localparam int NB = DATA_W / 8;

  logic              awvalid, awready;
  logic [ID_W-1:0]   awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid, wready;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     wstrb;
  logic              wlast;

  logic              bvalid, bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  logic              arvalid, arready;
  logic [ID_W-1:0]   arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              cons_valid;
  logic [7:0]        cons_data;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast, bready,
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast,
    output cons_valid, cons_data
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast, bready,
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast,
    input  cons_valid, cons_data
  );
endinterface

// File: rtl/axi4_mem_slave.sv
// AXI4 slave memory model: independent single-outstanding read and write engines
// over a byte-addressed memory, with a console byte sink at CONS_ADDR.
module axi4_mem_slave #(
  parameter int          DATA_W     = 32,
  parameter int          ID_W       = 4,
  parameter int          MEM_BYTES  = 2**20,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [31:0] CONS_ADDR  = 32'ha000_03f8,
  parameter int          RD_LATENCY = 1,
  parameter int          WR_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset,
  axi4_mem_slave_if.slave  bus
);
  localparam int NB        = DATA_W / 8;
  localparam int NB_LG     = $clog2(NB);
  localparam int AW        = $clog2(MEM_BYTES);
  localparam int CONS_LANE = int'(CONS_ADDR[NB_LG-1:0]);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_LAT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_e;

  function automatic logic [31:0] align(input logic [31:0] addr);
    return addr & ~32'(NB - 1);
  endfunction

  function automatic logic in_range(input logic [31:0] addr);
    return (addr - BASE_ADDR) < 32'(MEM_BYTES);
  endfunction

  function automatic logic [AW-1:0] mem_idx(input logic [31:0] addr);
    return AW'(align(addr) - BASE_ADDR);
  endfunction

  // Sizes wider than the bus clamp to the bus width; malformed WRAP lengths fall back to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [2:0]  sz;
    logic [31:0] bytes, tot;
    sz    = (size > 3'(NB_LG)) ? 3'(NB_LG) : size;
    bytes = 32'd1 << sz;
    tot   = bytes * (32'(len) + 32'd1);
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && (len inside {8'd1, 8'd3, 8'd7, 8'd15}))
      return (addr & ~(tot - 32'd1)) | ((addr + bytes) & (tot - 32'd1));
    return (addr & ~(bytes - 32'd1)) + bytes;
  endfunction

  logic [7:0] mem [MEM_BYTES];

  // ---------------- read engine ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [31:0]       r_addr_q, r_addr_d;
  logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic [2:0]        r_size_q, r_size_d;
  logic [1:0]        r_burst_q, r_burst_d;
  logic [15:0]       r_lat_q, r_lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic [31:0]       r_next_addr, r_fetch_addr;
  logic [DATA_W-1:0] r_word;
  logic              r_fetch;

  assign r_next_addr  = next_addr(r_addr_q, r_size_q, r_len_q, r_burst_q);
  assign r_fetch_addr = (r_state_q == R_IDLE) ? bus.araddr : r_next_addr;

  always_comb begin
    r_word = '0;
    for (int i = 0; i < NB; i++) r_word[i*8 +: 8] = mem[mem_idx(r_fetch_addr) + AW'(i)];
  end

  // Read data is captured at the fetch edge so it stays stable through a stalled R beat.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_lat_d   = r_lat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    r_fetch   = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (bus.arvalid) begin
        r_id_d    = bus.arid;
        r_addr_d  = bus.araddr;
        r_len_d   = bus.arlen;
        r_size_d  = bus.arsize;
        r_burst_d = bus.arburst;
        r_beat_d  = 8'd0;
        r_lat_d   = 16'd1;
        rlast_d   = (bus.arlen == 8'd0);
        r_fetch   = 1'b1;
        r_state_d = (RD_LATENCY > 1) ? R_LAT : R_DATA;
      end
      R_LAT: begin
        if (r_lat_q == 16'(RD_LATENCY - 1)) r_state_d = R_DATA;
        else                                r_lat_d   = r_lat_q + 16'd1;
      end
      R_DATA: if (bus.rready) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_addr_d = r_next_addr;
          r_beat_d = r_beat_q + 8'd1;
          rlast_d  = (r_beat_q + 8'd1 == r_len_q);
          r_fetch  = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_fetch) begin
      rdata_d = in_range(r_fetch_addr) ? r_word : '0;
      rresp_d = in_range(r_fetch_addr) ? RESP_OKAY : RESP_DECERR;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_lat_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_lat_q   <= r_lat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = (r_state_q == R_DATA);
  assign bus.rid     = r_id_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;

  // ---------------- write engine ----------------
  w_state_e        w_state_q, w_state_d;
  logic [ID_W-1:0] w_id_q, w_id_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [7:0]      w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic [2:0]      w_size_q, w_size_d;
  logic [1:0]      w_burst_q, w_burst_d;
  logic [15:0]     w_lat_q, w_lat_d;
  logic            w_dec_q, w_dec_d, w_slv_q, w_slv_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            cons_valid_q, cons_valid_d;
  logic [7:0]      cons_data_q, cons_data_d;
  logic            w_is_cons, w_in_range, w_at_len, w_fire, w_mem_we;

  assign w_is_cons  = (align(w_addr_q) == align(CONS_ADDR));
  assign w_in_range = in_range(w_addr_q);
  assign w_at_len   = (w_beat_q == w_len_q);
  assign w_fire     = (w_state_q == W_DATA) && bus.wvalid;
  assign w_mem_we   = w_fire && w_in_range && !w_is_cons && !reset;

  always_comb begin
    w_state_d    = w_state_q;
    w_id_d       = w_id_q;
    w_addr_d     = w_addr_q;
    w_len_d      = w_len_q;
    w_size_d     = w_size_q;
    w_burst_d    = w_burst_q;
    w_beat_d     = w_beat_q;
    w_lat_d      = w_lat_q;
    w_dec_d      = w_dec_q;
    w_slv_d      = w_slv_q;
    bresp_d      = bresp_q;
    cons_valid_d = 1'b0;
    cons_data_d  = cons_data_q;
    unique case (w_state_q)
      W_IDLE: if (bus.awvalid) begin
        w_id_d    = bus.awid;
        w_addr_d  = bus.awaddr;
        w_len_d   = bus.awlen;
        w_size_d  = bus.awsize;
        w_burst_d = bus.awburst;
        w_beat_d  = 8'd0;
        w_dec_d   = 1'b0;
        w_slv_d   = 1'b0;
        w_state_d = W_DATA;
      end
      W_DATA: if (w_fire) begin
        if (w_is_cons && bus.wstrb[CONS_LANE]) begin
          cons_valid_d = 1'b1;
          cons_data_d  = bus.wdata[CONS_LANE*8 +: 8];
        end
        w_dec_d  = w_dec_q | (!w_in_range && !w_is_cons);
        w_slv_d  = w_slv_q | (bus.wlast != w_at_len);
        w_addr_d = next_addr(w_addr_q, w_size_q, w_len_q, w_burst_q);
        w_beat_d = w_beat_q + 8'd1;
        if (bus.wlast || w_at_len) begin
          bresp_d   = w_dec_d ? RESP_DECERR : (w_slv_d ? RESP_SLVERR : RESP_OKAY);
          w_lat_d   = 16'd1;
          w_state_d = (WR_LATENCY > 1) ? W_LAT : W_RESP;
        end
      end
      W_LAT: begin
        if (w_lat_q == 16'(WR_LATENCY - 1)) w_state_d = W_RESP;
        else                                w_lat_d   = w_lat_q + 16'd1;
      end
      W_RESP: if (bus.bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q    <= W_IDLE;
      w_id_q       <= '0;
      w_addr_q     <= '0;
      w_len_q      <= '0;
      w_size_q     <= '0;
      w_burst_q    <= '0;
      w_beat_q     <= '0;
      w_lat_q      <= '0;
      w_dec_q      <= 1'b0;
      w_slv_q      <= 1'b0;
      bresp_q      <= '0;
      cons_valid_q <= 1'b0;
      cons_data_q  <= '0;
    end else begin
      w_state_q    <= w_state_d;
      w_id_q       <= w_id_d;
      w_addr_q     <= w_addr_d;
      w_len_q      <= w_len_d;
      w_size_q     <= w_size_d;
      w_burst_q    <= w_burst_d;
      w_beat_q     <= w_beat_d;
      w_lat_q      <= w_lat_d;
      w_dec_q      <= w_dec_d;
      w_slv_q      <= w_slv_d;
      bresp_q      <= bresp_d;
      cons_valid_q <= cons_valid_d;
      cons_data_q  <= cons_data_d;
    end
  end

  // NOTE: the memory array has no reset; its contents must survive a reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      for (int i = 0; i < NB; i++)
        if (bus.wstrb[i]) mem[mem_idx(w_addr_q) + AW'(i)] <= bus.wdata[i*8 +: 8];
    end
  end

  assign bus.awready    = (w_state_q == W_IDLE);
  assign bus.wready     = (w_state_q == W_DATA);
  assign bus.bvalid     = (w_state_q == W_RESP);
  assign bus.bid        = w_id_q;
  assign bus.bresp      = bresp_q;
  assign bus.cons_valid = cons_valid_q;
  assign bus.cons_data  = cons_data_q;
endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: 32-bit bus, 4 KiB memory, read latency 3, write latency 1.
module tb_axi4_mem_slave;
  localparam int          MEM_BYTES = 4096;
  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam logic [31:0] CONS      = 32'ha000_03f8;
  localparam logic [1:0]  FIXED     = 2'b00;
  localparam logic [1:0]  INCR      = 2'b01;
  localparam logic [1:0]  WRAP      = 2'b10;
  localparam int          BUDGET    = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi4_mem_slave_if #(.DATA_W(32), .ID_W(4)) bus ();

  axi4_mem_slave #(
    .DATA_W(32), .ID_W(4), .MEM_BYTES(MEM_BYTES), .BASE_ADDR(BASE),
    .CONS_ADDR(CONS), .RD_LATENCY(3), .WR_LATENCY(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];
  logic [31:0] rdat [16];
  logic [1:0]  rrsp [16];
  logic        rlst [16];
  logic [3:0]  rid_got, bid_got;
  logic [1:0]  bresp_got;

  int cyc = 0, cons_cnt = 0, cons_cyc = -1, hs_cyc = -2;
  logic [7:0] cons_last = '0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (bus.cons_valid) begin
    cons_cnt  <= cons_cnt + 1;
    cons_cyc  <= cyc;
    cons_last <= bus.cons_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = len; bus.awsize = 3'd2; bus.awburst = burst;
    while (!bus.awready && n < BUDGET) begin @(negedge clock); n++; end
    check("awready", 32'(bus.awready), 32'd1);
    @(negedge clock);
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
    while (!bus.wready && n < BUDGET) begin @(negedge clock); n++; end
    check("wready", 32'(bus.wready), 32'd1);
    @(negedge clock);
    hs_cyc = cyc;
  endtask

  // Sends a burst of nbeats beats, raising wlast on beat wlast_at, then collects B.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int wlast_at);
    int n = 0;
    aw_send(id, addr, len, burst);
    for (int i = 0; i < nbeats; i++) w_beat(wdat[i], wstb[i], i == wlast_at);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("wready_after_last", 32'(bus.wready), 32'd0);
    check("bvalid_latency", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    while (!bus.bvalid && n < BUDGET) begin @(negedge clock); n++; end
    bresp_got = bus.bresp; bid_got = bus.bid;
    @(negedge clock);
    bus.bready = 1'b0;
    check("awready_after_b", 32'(bus.awready), 32'd1);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
    bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst;
    while (!bus.arready && n < BUDGET) begin @(negedge clock); n++; end
    check("arready", 32'(bus.arready), 32'd1);
    @(negedge clock);
    bus.arvalid = 1'b0;
  endtask

  task automatic r_recv(input int i, output int waits);
    waits = 0;
    while (!bus.rvalid && waits < BUDGET) begin @(negedge clock); waits++; end
    check("rvalid", 32'(bus.rvalid), 32'd1);
    rdat[i] = bus.rdata; rrsp[i] = bus.rresp; rlst[i] = bus.rlast; rid_got = bus.rid;
    @(negedge clock);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int waits;
    ar_send(id, addr, len, burst);
    bus.rready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      r_recv(i, waits);
      if (i > 0) check($sformatf("r_back_to_back%0d", i), 32'(waits), 32'd0);
    end
    bus.rready = 1'b0;
    check("arready_after_r", 32'(bus.arready), 32'd1);
    check("rid", 32'(rid_got), 32'(id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rlast",   32'(bus.rlast),   32'd0);
    check("rst_cons",    32'(bus.cons_valid), 32'd0);
    check("rst_resps",   32'({bus.bresp, bus.rresp, bus.bid, bus.rid}), 32'd0);
    check("rst_rdata",   bus.rdata, 32'd0);

    // Preload words 0x00..0x0C
    wdat[0] = 32'h1122_3344; wdat[1] = 32'h5566_7788; wdat[2] = 32'h99aa_bbcc; wdat[3] = 32'hddee_ff00;
    for (int i = 0; i < 4; i++) wstb[i] = 4'hf;
    do_write(4'h3, BASE, 8'd3, INCR, 4, 3);
    check("pre_bresp", 32'(bresp_got), 32'd0);
    check("pre_bid",   32'(bid_got),   32'd3);

    // Read latency: AR at T, rvalid at T+3, stable while stalled
    bus.arvalid = 1'b1; bus.arid = 4'h9; bus.araddr = BASE; bus.arlen = 8'd0;
    bus.arsize = 3'd2; bus.arburst = INCR;
    check("lat_arready_T", 32'(bus.arready), 32'd1);
    @(negedge clock); bus.arvalid = 1'b0;
    check("lat_arready_T1", 32'(bus.arready), 32'd0);
    check("lat_rvalid_T1",  32'(bus.rvalid),  32'd0);
    @(negedge clock);
    check("lat_rvalid_T2",  32'(bus.rvalid),  32'd0);
    @(negedge clock);
    check("lat_rvalid_T3",  32'(bus.rvalid),  32'd1);
    check("lat_rdata",      bus.rdata, 32'h1122_3344);
    check("lat_rresp",      32'(bus.rresp), 32'd0);
    check("lat_rlast",      32'(bus.rlast), 32'd1);
    check("lat_rid",        32'(bus.rid),   32'h9);
    @(negedge clock);
    check("lat_hold_rvalid", 32'(bus.rvalid), 32'd1);
    check("lat_hold_rdata",  bus.rdata, 32'h1122_3344);
    bus.rready = 1'b1;
    @(negedge clock); bus.rready = 1'b0;
    check("lat_arready_after", 32'(bus.arready), 32'd1);
    check("lat_rvalid_after",  32'(bus.rvalid),  32'd0);

    // INCR write with partial strobe on beat 2
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'haaaa_aaaa; wstb[i] = 4'hf; end
    do_write(4'h1, BASE + 32'h100, 8'd3, INCR, 4, 3);
    wdat[0] = 32'h1010_1010; wdat[1] = 32'h2020_2020; wdat[2] = 32'hddcc_bbaa; wdat[3] = 32'h4040_4040;
    wstb[2] = 4'b0101;
    do_write(4'h2, BASE + 32'h100, 8'd3, INCR, 4, 3);
    check("strb_bresp", 32'(bresp_got), 32'd0);
    do_read(4'h2, BASE + 32'h100, 8'd3, INCR);
    check("strb_b0", rdat[0], 32'h1010_1010);
    check("strb_b1", rdat[1], 32'h2020_2020);
    check("strb_b2", rdat[2], 32'haacc_aaaa);
    check("strb_b3", rdat[3], 32'h4040_4040);
    check("strb_rlast", 32'({rlst[0], rlst[1], rlst[2], rlst[3]}), 32'b0001);

    // WRAP read len=3 at 0x08: 0x08, 0x0C, 0x00, 0x04
    do_read(4'h4, BASE + 32'h8, 8'd3, WRAP);
    check("wrap_b0", rdat[0], 32'h99aa_bbcc);
    check("wrap_b1", rdat[1], 32'hddee_ff00);
    check("wrap_b2", rdat[2], 32'h1122_3344);
    check("wrap_b3", rdat[3], 32'h5566_7788);

    // FIXED read repeats the same word
    do_read(4'h5, BASE + 32'h4, 8'd1, FIXED);
    check("fixed_b0", rdat[0], 32'h5566_7788);
    check("fixed_b1", rdat[1], 32'h5566_7788);

    // Out-of-range read: second beat crosses the top of memory
    wdat[0] = 32'hcafe_f00d; wstb[0] = 4'hf;
    do_write(4'h6, BASE + 32'(MEM_BYTES) - 32'd4, 8'd0, INCR, 1, 0);
    do_read(4'h6, BASE + 32'(MEM_BYTES) - 32'd4, 8'd1, INCR);
    check("oor_b0_data", rdat[0], 32'hcafe_f00d);
    check("oor_b0_resp", 32'({rrsp[0], rlst[0]}), 32'b000);
    check("oor_b1_data", rdat[1], 32'd0);
    check("oor_b1_resp", 32'({rrsp[1], rlst[1]}), 32'b111);

    // Out-of-range write gets DECERR and must not alias onto memory
    wdat[0] = 32'h0bad_0bad;
    do_write(4'h7, BASE + 32'(MEM_BYTES), 8'd0, INCR, 1, 0);
    check("oor_w_bresp", 32'(bresp_got), 32'd3);

    // Early wlast on beat 1 of a len=3 burst
    wdat[0] = 32'h0101_0101; wdat[1] = 32'h0202_0202;
    do_write(4'h8, BASE + 32'h200, 8'd3, INCR, 2, 1);
    check("slv_bresp", 32'(bresp_got), 32'd2);
    check("slv_bid",   32'(bid_got),   32'd8);
    do_read(4'h8, BASE + 32'h200, 8'd1, INCR);
    check("slv_mem0", rdat[0], 32'h0101_0101);
    check("slv_mem1", rdat[1], 32'h0202_0202);

    // Console byte: one pulse, no memory side effect (CONS aliases offset 0x3F8)
    wdat[0] = 32'h5a5a_5a5a;
    do_write(4'h1, BASE + 32'h3f8, 8'd0, INCR, 1, 0);
    check("cons_idle_cnt", 32'(cons_cnt), 32'd0);
    wdat[0] = 32'h0000_0041; wstb[0] = 4'b0001;
    do_write(4'h5, CONS, 8'd0, INCR, 1, 0);
    check("cons_bresp", 32'(bresp_got), 32'd0);
    check("cons_cnt",   32'(cons_cnt),  32'd1);
    check("cons_data",  32'(cons_last), 32'h41);
    check("cons_timing", 32'(cons_cyc), 32'(hs_cyc));
    do_read(4'h1, BASE + 32'h3f8, 8'd0, INCR);
    check("cons_mem", rdat[0], 32'h5a5a_5a5a);

    // Reset during beat 2 of a len=7 read
    ar_send(4'ha, BASE, 8'd7, INCR);
    bus.rready = 1'b1;
    r_recv(0, waits);
    r_recv(1, waits);
    check("rst_mid_beat2", 32'(bus.rvalid), 32'd1);
    reset = 1'b1; bus.rready = 1'b0;
    @(negedge clock);
    check("rst_mid_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_mid_arready", 32'(bus.arready), 32'd1);
    reset = 1'b0;
    do_read(4'hb, BASE, 8'd0, INCR);
    check("post_rst_data", rdat[0], 32'h1122_3344);
    check("post_rst_resp", 32'({rrsp[0], rlst[0]}), 32'b001);

    // The earlier out-of-range write must not have touched word 0 of memory either
    check("oor_w_noalias", rdat[0], 32'h1122_3344);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
